dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 2, cycles from request acceptance to resp_valid; legal range 1..15.
REQ-002 Parameter ADDR_WIDTH, default 17, byte-address width of backing RAM (2^ADDR_WIDTH bytes).
REQ-003 Parameter IO_ADDR, default 32'hFFFF_FFFC, word address of read-only input port.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  initiator presents request.
REQ-007 req_ready  output  1  responder accepts request this cycle.
REQ-008 req_write  input  1  1=store, 0=load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 req_width  input  3  RISC-V funct3: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  initiator consumes response.
REQ-014 resp_rdata  output  32  load data, extended to 32 bits.
REQ-015 resp_err  output  1  request faulted.
REQ-016 ioin  input  32  external input sampled on IO_ADDR loads.

Function
REQ-017 FSM states IDLE, WAIT, RESP; exactly one request outstanding.
REQ-018 IDLE: req_ready=1; req_valid&req_ready at edge N = accept; latch addr/width/write/wdata; go to WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-019 WAIT: down-counter loaded with LATENCY-1 at accept; to RESP when counter reaches 1; req_ready=0.
REQ-020 RESP: resp_valid=1, resp_rdata/resp_err stable until resp_valid&resp_ready edge, then IDLE; resp_valid first high LATENCY cycles after accept edge.
REQ-021 req_ready=0 in WAIT and RESP; new accept earliest the cycle after response handshake.
REQ-022 RAM little-endian byte array, index req_addr[ADDR_WIDTH-1:0]; no reset of contents.
REQ-023 Load byte/half: signed widths sign-extend, unsigned zero-extend; word returned unmodified.
REQ-024 Store byte/half/word writes only addressed bytes from req_wdata low bytes; commit on accept edge.
REQ-025 Store response: resp_rdata=0, resp_err=0.
REQ-026 Load from IO_ADDR (width 010 only): resp_rdata = ioin sampled at accept edge.
REQ-027 Error (resp_err=1, resp_rdata=0, no RAM write): half with addr[0]=1; word with addr[1:0]!=0; width 011/110/111; store with 100/101; store to IO_ADDR; non-word IO_ADDR load; addr >= 2^ADDR_WIDTH and != IO_ADDR.
REQ-028 Errored requests obey same latency and handshake as good ones.
REQ-029 Load following store to same address returns stored data.

Reset
REQ-030 rst high: state IDLE, counter 0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, immediately (asynchronous).
REQ-031 rst release: req_ready=1 from next cycle; in-flight request discarded, no response; committed stores remain.

Verification
REQ-032 sw 0x12345678 @0x100, then lw @0x100, LATENCY=2 -> resp_valid 2 cycles after each accept; load rdata 0x12345678, err 0.
REQ-033 sb 0x80 @0x201, lb @0x201 -> 0xFFFFFF80; lbu @0x201 -> 0x00000080; lh @0x200 (byte0 = 0x00) -> 0xFFFF8000.
REQ-034 lw @0x102 -> resp_err=1, rdata 0; sh @0x103 -> err 1, following lw @0x100 unchanged.
REQ-035 ioin=0xDEADBEEF, lw @IO_ADDR -> rdata 0xDEADBEEF; sw @IO_ADDR -> err 1.
REQ-036 resp_ready held 0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready=0; request held during that time not accepted.
REQ-037 rst asserted in WAIT -> outputs zero immediately; after release no resp_valid, req_ready=1 next cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with fixed latency.
// Backs a little-endian byte RAM plus one read-only word input port at IO_ADDR.
// Stores commit and load data is captured on the accept edge. The response
// stays registered until the initiator takes it.
module dmem_responder #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter logic [31:0] IO_ADDR    = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_width,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic [31:0] ioin
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [7:0]  mem [2**ADDR_WIDTH];

  logic                  accept, req_err, is_io, in_range, we;
  logic [ADDR_WIDTH-1:0] idx0, idx1, idx2, idx3;
  logic [63:0]           addr_ext;
  logic [31:0]           load_data;

  assign req_ready  = (state_q == S_IDLE) & ~rst;
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Byte lanes; misaligned accesses fault, so lane offsets never straddle a word.
  assign idx0 = req_addr[ADDR_WIDTH-1:0];
  assign idx1 = idx0 + ADDR_WIDTH'(1);
  assign idx2 = idx0 + ADDR_WIDTH'(2);
  assign idx3 = idx0 + ADDR_WIDTH'(3);

  assign addr_ext = {32'd0, req_addr};
  assign in_range = (addr_ext >> ADDR_WIDTH) == 64'd0;
  assign is_io    = (req_addr == IO_ADDR);
  assign we       = accept & req_write & ~req_err;

  // Fault classification: bad width, misalignment, illegal IO use, out of range.
  always_comb begin
    req_err = 1'b0;
    case (req_width)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = req_addr[0];
      3'b010:         req_err = |req_addr[1:0];
      default:        req_err = 1'b1;
    endcase
    if (req_write && req_width[2])                  req_err = 1'b1;
    if (is_io && (req_write || req_width != 3'b010)) req_err = 1'b1;
    if (!is_io && !in_range)                         req_err = 1'b1;
  end

  // Load data with sign/zero extension; IO word reads come straight from ioin.
  always_comb begin
    load_data = 32'd0;
    case (req_width)
      3'b000:  load_data = {{24{mem[idx0][7]}}, mem[idx0]};
      3'b100:  load_data = {24'd0, mem[idx0]};
      3'b001:  load_data = {{16{mem[idx1][7]}}, mem[idx1], mem[idx0]};
      3'b101:  load_data = {16'd0, mem[idx1], mem[idx0]};
      3'b010:  load_data = is_io ? ioin : {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
      default: load_data = 32'd0;
    endcase
  end

  // Next-state: accept in IDLE, count down in WAIT, hold response until taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rdata_d = (req_write || req_err) ? 32'd0 : load_data;
          err_d   = req_err;
          if (LATENCY > 1) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM byte-lane writes on the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      case (req_width[1:0])
        2'b00: mem[idx0] <= req_wdata[7:0];
        2'b01: begin
          mem[idx0] <= req_wdata[7:0];
          mem[idx1] <= req_wdata[15:8];
        end
        default: begin
          mem[idx0] <= req_wdata[7:0];
          mem[idx1] <= req_wdata[15:8];
          mem[idx2] <= req_wdata[23:16];
          mem[idx3] <= req_wdata[31:24];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at default parameters (LATENCY=2).
module tb_dmem_responder;
  localparam logic [31:0] IO = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, ioin = '0;
  logic [2:0]  req_width = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_width(req_width), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .ioin(ioin)
  );

  // Issue one request, wait for its response, take it. lat counts cycles
  // from the accept edge to the edge where resp_valid is first high (0 = timeout).
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_width = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    if (lat != 0) begin
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", resp_valid); end
    total++; if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin bad++; $display("FAIL reset_data got=%h/%b want=0/0", resp_rdata, resp_err); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h100, 32'h1234_5678, 3'b010, rd, er, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d want=2", lat); end
    total++; if (rd !== 32'd0 || er !== 1'b0) begin bad++; $display("FAIL sw_resp got=%h/%b want=0/0", rd, er); end
    do_req(1'b0, 32'h100, 32'h0, 3'b010, rd, er, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency got=%0d want=2", lat); end
    total++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin bad++; $display("FAIL lw_data got=%h/%b want=12345678/0", rd, er); end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h200, 32'h0000_0000, 3'b000, rd, er, lat);
    do_req(1'b1, 32'h201, 32'h0000_0080, 3'b000, rd, er, lat);
    do_req(1'b0, 32'h201, 32'h0, 3'b000, rd, er, lat);
    total++; if (rd !== 32'hFFFF_FF80 || er !== 1'b0) begin bad++; $display("FAIL lb got=%h/%b want=ffffff80/0", rd, er); end
    do_req(1'b0, 32'h201, 32'h0, 3'b100, rd, er, lat);
    total++; if (rd !== 32'h0000_0080) begin bad++; $display("FAIL lbu got=%h want=00000080", rd); end
    do_req(1'b0, 32'h200, 32'h0, 3'b001, rd, er, lat);
    total++; if (rd !== 32'hFFFF_8000) begin bad++; $display("FAIL lh got=%h want=ffff8000", rd); end
    do_req(1'b0, 32'h200, 32'h0, 3'b101, rd, er, lat);
    total++; if (rd !== 32'h0000_8000) begin bad++; $display("FAIL lhu got=%h want=00008000", rd); end
    do_req(1'b1, 32'h300, 32'h1122_3344, 3'b010, rd, er, lat);
    do_req(1'b1, 32'h302, 32'hFFFF_FFAA, 3'b000, rd, er, lat);
    do_req(1'b1, 32'h304, 32'h0000_BEEF, 3'b010, rd, er, lat);
    do_req(1'b1, 32'h306, 32'h1234_CAFE, 3'b001, rd, er, lat);
    do_req(1'b0, 32'h300, 32'h0, 3'b010, rd, er, lat);
    total++; if (rd !== 32'h11AA_3344) begin bad++; $display("FAIL sb_lane got=%h want=11aa3344", rd); end
    do_req(1'b0, 32'h304, 32'h0, 3'b010, rd, er, lat);
    total++; if (rd !== 32'hCAFE_BEEF) begin bad++; $display("FAIL sh_lane got=%h want=cafebeef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 32'h102, 32'h0, 3'b010, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 2) begin bad++; $display("FAIL lw_misalign got=%b/%h/%0d want=1/0/2", er, rd, lat); end
    do_req(1'b1, 32'h103, 32'hFFFF_FFFF, 3'b001, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL sh_misalign got=%b want=1", er); end
    do_req(1'b1, 32'h100, 32'h0000_00EE, 3'b100, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL store_unsigned got=%b want=1", er); end
    do_req(1'b0, 32'h100, 32'h0, 3'b010, rd, er, lat);
    total++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin bad++; $display("FAIL lw_unchanged got=%h/%b want=12345678/0", rd, er); end
    do_req(1'b0, 32'h100, 32'h0, 3'b011, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL width011 got=%b/%h want=1/0", er, rd); end
    do_req(1'b0, 32'h0002_0000, 32'h0, 3'b010, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL out_of_range got=%b want=1", er); end
    do_req(1'b0, 32'h0001_FFFC, 32'h0, 3'b010, rd, er, lat);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL top_word got=%b want=0", er); end
  endtask

  task automatic test_io();
    logic [31:0] rd; logic er; int lat;
    ioin = 32'hDEAD_BEEF;
    do_req(1'b0, IO, 32'h0, 3'b010, rd, er, lat);
    total++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin bad++; $display("FAIL io_load got=%h/%b want=deadbeef/0", rd, er); end
    do_req(1'b1, IO, 32'h5, 3'b010, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL io_store got=%b want=1", er); end
    do_req(1'b0, IO, 32'h0, 3'b001, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL io_half got=%b want=1", er); end
    // ioin must be captured at the accept edge, not at response time
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = IO; req_width = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0; ioin = 32'h0BAD_F00D;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin lat = i; break; end
    end
    total++; if (lat !== 2 || resp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL io_sample got=%h lat=%0d want=deadbeef lat=2", resp_rdata, lat); end
    resp_ready = 1'b1; @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    int stable_bad;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_width = 3'b010;
    @(posedge clk);
    #1 req_addr = 32'h300;   // held request stays valid while busy
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin lat = i; break; end
    end
    total++; if (lat !== 2) begin bad++; $display("FAIL bp_latency got=%0d want=2", lat); end
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h1234_5678 || req_ready !== 1'b0) stable_bad++;
    end
    total++; if (stable_bad !== 0) begin bad++; $display("FAIL bp_stable got=%0d bad cycles want=0", stable_bad); end
    resp_ready = 1'b1; @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_after got=%b/%b want=0/1", resp_valid, req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin lat = i; break; end
    end
    total++; if (lat !== 2 || resp_rdata !== 32'h11AA_3344) begin bad++; $display("FAIL bp_held got=%h lat=%0d want=11aa3344 lat=2", resp_rdata, lat); end
    resp_ready = 1'b1; @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset_inflight();
    logic [31:0] rd; logic er; int lat;
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_width = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0)
      begin bad++; $display("FAIL rst_async got=%b/%b/%h/%b want=0/0/0/0", resp_valid, req_ready, resp_rdata, resp_err); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_no_resp got=%0d want=0", seen); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", req_ready); end
    do_req(1'b0, 32'h100, 32'h0, 3'b010, rd, er, lat);
    total++; if (rd !== 32'h1234_5678 || lat !== 2) begin bad++; $display("FAIL rst_mem_kept got=%h lat=%0d want=12345678 lat=2", rd, lat); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_io();
    test_backpressure();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
